// File: rtl/icache_pkg.sv
// Shared icache refill types: FSM state, CAM flag codes and address slices.
// Physical word addresses are carried as [28:2]; tag is [28:12], offset [3:2].
package icache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } refill_state_e;

    localparam logic [1:0] FLAG_VALID   = 2'b01;
    localparam logic [1:0] FLAG_INVALID = 2'b00;

    localparam int LINE_WORDS = 4;
    localparam int OFF_W      = $clog2(LINE_WORDS);

    typedef logic [28:2]      paddr_t;
    typedef logic [28:12]     tag_t;
    typedef logic [OFF_W-1:0] off_t;

    function automatic tag_t tag_of(input paddr_t a);
        return a[28:12];
    endfunction

    function automatic off_t off_of(input paddr_t a);
        return a[3:2];
    endfunction

    function automatic paddr_t line_base(input paddr_t a);
        return {a[28:4], 2'b00};
    endfunction

endpackage

// File: rtl/ic_refill_if.sv
// Refill engine signal bundle: fetch1 miss side, memory bus, CAM write port.
// master = refill engine, slave = its environment (fetch1/bus/CAM).
interface ic_refill_if;
    import icache_pkg::*;

    logic        miss_req;
    logic        miss_ready;
    paddr_t      miss_paddr;
    logic        miss_kill;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;

    logic        bus_req;
    paddr_t      bus_addr;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_err;

    logic        cam_write_req;
    logic        cam_write_lru_way;
    logic [1:0]  cam_write_offset;
    logic [31:0] cam_write_data;
    tag_t        cam_write_tag;
    logic [1:0]  cam_write_flags;
    logic        cam_lru_update;

    modport master (
        input  miss_req, miss_paddr, miss_kill,
        input  bus_gnt, bus_rvalid, bus_rdata, bus_err,
        output miss_ready, resp_valid, resp_data, resp_err,
        output bus_req, bus_addr,
        output cam_write_req, cam_write_lru_way, cam_write_offset,
        output cam_write_data, cam_write_tag, cam_write_flags,
        output cam_lru_update
    );

    modport slave (
        output miss_req, miss_paddr, miss_kill,
        output bus_gnt, bus_rvalid, bus_rdata, bus_err,
        input  miss_ready, resp_valid, resp_data, resp_err,
        input  bus_req, bus_addr,
        input  cam_write_req, cam_write_lru_way, cam_write_offset,
        input  cam_write_data, cam_write_tag, cam_write_flags,
        input  cam_lru_update
    );

endinterface

// File: rtl/ic_refill_wdog.sv
// Saturating idle-cycle watchdog for the refill engine.
// o_sat rises once the counter holds all-ones; i_clr has priority.
module ic_refill_wdog #(
    parameter int W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_sat
);

    logic [W-1:0] r_cnt;

    assign o_sat = &r_cnt;

    // Count idle cycles, hold at saturation, restart on clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_sat) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ic_refill.sv
// Icache miss/refill engine: 4-beat line burst, CAM fill, word forward, LRU.
// Define IC_REFILL_CWF_EN for critical-word-first bursts and early response.
module ic_refill
    import icache_pkg::*;
#(
    parameter int TIMEOUT_W = 8
) (
    input  logic        clk_core,
    input  logic        reset,
    ic_refill_if.master rif
);

    refill_state_e r_state;
    refill_state_e w_next;

    paddr_t      r_paddr;
    logic        r_kill;
    logic        r_err;
    off_t        r_nbeat;
    logic [31:0] r_resp_data;

    logic        r_cam_req;
    off_t        r_cam_off;
    logic [31:0] r_cam_data;
    tag_t        r_cam_tag;
    logic [1:0]  r_cam_flags;

    logic w_accept;
    logic w_active;
    logic w_wd_clr;
    logic w_wd_sat;
    logic w_timeout;
    logic w_beat;
    logic w_beat_ok;
    logic w_beat_err;
    logic w_last;
    logic w_killed;
    off_t w_start;
    off_t w_off;

`ifdef IC_REFILL_CWF_EN
    logic r_early;
    logic r_sent;
    assign w_start = off_of(r_paddr);
`else
    assign w_start = '0;
`endif

    assign w_accept   = (r_state == ST_IDLE) && rif.miss_req;
    assign w_active   = (r_state == ST_REQ) || (r_state == ST_DATA);
    assign w_wd_clr   = !w_active || rif.bus_gnt || rif.bus_rvalid;
    assign w_timeout  = w_active && w_wd_sat;
    assign w_beat     = (r_state == ST_DATA) && rif.bus_rvalid && !w_timeout;
    assign w_beat_ok  = w_beat && !rif.bus_err;
    assign w_beat_err = w_beat && rif.bus_err;
    assign w_off      = r_nbeat + w_start;
    assign w_last     = w_beat_ok && (r_nbeat == off_t'(LINE_WORDS - 1));
    assign w_killed   = r_kill || rif.miss_kill;

    ic_refill_wdog #(
        .W(TIMEOUT_W)
    ) u_wdog (
        .clk  (clk_core),
        .rst  (reset),
        .i_en (w_active),
        .i_clr(w_wd_clr),
        .o_sat(w_wd_sat)
    );

    // FSM state register.
    always_ff @(posedge clk_core or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state: request, burst, single-cycle completion.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_REQ;
            ST_REQ: begin
                if (w_timeout) begin
                    w_next = ST_DONE;
                end else if (rif.bus_gnt) begin
                    w_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_timeout || w_beat_err || w_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // FSM outputs: handshake, completion pulses.
    always_comb begin
        rif.miss_ready     = (r_state == ST_IDLE);
        rif.bus_req        = (r_state == ST_REQ) && !w_timeout;
        rif.resp_err       = (r_state == ST_DONE) && r_err;
        rif.cam_lru_update = (r_state == ST_DONE) && !r_err;
`ifdef IC_REFILL_CWF_EN
        rif.resp_valid = r_early ||
                         ((r_state == ST_DONE) && r_err &&
                          !r_sent && !w_killed);
`else
        rif.resp_valid = (r_state == ST_DONE) && !w_killed;
`endif
    end

    // Miss context: address, sticky kill/error, beat count, critical word.
    always_ff @(posedge clk_core or posedge reset) begin
        if (reset) begin
            r_paddr     <= '0;
            r_kill      <= 1'b0;
            r_err       <= 1'b0;
            r_nbeat     <= '0;
            r_resp_data <= '0;
        end else if (w_accept) begin
            r_paddr     <= rif.miss_paddr;
            r_kill      <= 1'b0;
            r_err       <= 1'b0;
            r_nbeat     <= '0;
            r_resp_data <= '0;
        end else begin
            if (r_state != ST_IDLE && rif.miss_kill) begin
                r_kill <= 1'b1;
            end
            if (w_timeout || w_beat_err) begin
                r_err <= 1'b1;
            end
            if (w_beat_ok) begin
                r_nbeat <= r_nbeat + 1'b1;
                if (w_off == off_of(r_paddr)) begin
                    r_resp_data <= rif.bus_rdata;
                end
            end
        end
    end

    // Registered CAM write, one cycle behind each good beat.
    always_ff @(posedge clk_core or posedge reset) begin
        if (reset) begin
            r_cam_req   <= 1'b0;
            r_cam_off   <= '0;
            r_cam_data  <= '0;
            r_cam_tag   <= '0;
            r_cam_flags <= FLAG_INVALID;
        end else begin
            r_cam_req <= w_beat_ok;
            if (w_beat_ok) begin
                r_cam_off   <= w_off;
                r_cam_data  <= rif.bus_rdata;
                r_cam_tag   <= tag_of(r_paddr);
                r_cam_flags <= w_last ? FLAG_VALID : FLAG_INVALID;
            end
        end
    end

`ifdef IC_REFILL_CWF_EN
    // Early response on the first (critical) beat; remember it was sent.
    always_ff @(posedge clk_core or posedge reset) begin
        if (reset) begin
            r_early <= 1'b0;
            r_sent  <= 1'b0;
        end else if (w_accept) begin
            r_early <= 1'b0;
            r_sent  <= 1'b0;
        end else begin
            r_early <= w_beat_ok && (r_nbeat == '0) && !w_killed;
            if (w_beat_ok && (r_nbeat == '0)) begin
                r_sent <= 1'b1;
            end
        end
    end
    assign rif.bus_addr = r_paddr;
`else
    assign rif.bus_addr = line_base(r_paddr);
`endif

    assign rif.resp_data         = r_resp_data;
    assign rif.cam_write_req     = r_cam_req;
    assign rif.cam_write_lru_way = 1'b1;
    assign rif.cam_write_offset  = r_cam_off;
    assign rif.cam_write_data    = r_cam_data;
    assign rif.cam_write_tag     = r_cam_tag;
    assign rif.cam_write_flags   = r_cam_flags;

endmodule
